// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor: bridges a cache full-line port to a narrower burst
// memory port. Writes are serialised into BEATS beats, reads are assembled
// from BEATS beats. One transaction is outstanding at a time.
// Optional feature macro: LBA_CRITICAL_WORD_FIRST_EN enables wrapped,
// critical-word-first reads with a beat-aligned memory address.
module line_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS    = LINE_W / BURST_W;
  localparam int CNT_W    = $clog2(BEATS);
  localparam int LINE_OFF = $clog2(LINE_W / 8);
  localparam int BEAT_OFF = $clog2(BURST_W / 8);

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_OFF;
  localparam logic [ADDR_W-1:0] BEAT_MASK = {ADDR_W{1'b1}} << BEAT_OFF;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  start;
  logic [CNT_W-1:0]  slot;
  logic [LINE_W-1:0] wline;
  logic              last_beat;

  assign last_beat = resp_i && (cnt == '1);
  assign slot      = start + cnt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    state_nx = state;
    read_o   = 1'b0;
    write_o  = 1'b0;
    resp_o   = 1'b0;
    unique case (state)
      IDLE: begin
        if (write_i)     state_nx = WRITE;
        else if (read_i) state_nx = READ;
      end
      READ: begin
        read_o = 1'b1;
        if (last_beat) state_nx = DONE;
      end
      WRITE: begin
        write_o = 1'b1;
        if (last_beat) state_nx = DONE;
      end
      DONE: begin
        resp_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, beat counter and read-line assembly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      start     <= '0;
      wline     <= '0;
      line_o    <= '0;
      address_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (write_i) begin
            address_o <= address_i & LINE_MASK;
            wline     <= line_i;
            start     <= '0;
            cnt       <= '0;
          end else if (read_i) begin
`ifdef LBA_CRITICAL_WORD_FIRST_EN
            address_o <= address_i & BEAT_MASK;
            start     <= address_i[LINE_OFF-1:BEAT_OFF];
`else
            address_o <= address_i & LINE_MASK;
            start     <= '0;
`endif
            cnt       <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
              if (slot == CNT_W'(b)) line_o[b*BURST_W +: BURST_W] <= burst_i;
            end
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          if (resp_i) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifndef LBA_CRITICAL_WORD_FIRST_EN
  // Beat-offset mask only matters for critical-word-first reads
  logic unused_mask;
  assign unused_mask = ^BEAT_MASK;
`endif

  // Write beat select from the latched line
  always_comb begin
    burst_o = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (cnt == CNT_W'(b)) burst_o = wline[b*BURST_W +: BURST_W];
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;

  logic         clk;
  logic         reset_n;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  logic [31:0]  address_i2;
  logic         read_i2;
  logic         write_i2;
  logic [511:0] line_i2;
  logic [511:0] line_o2;
  logic         resp_o2;
  logic [31:0]  address_o2;
  logic         read_o2;
  logic         write_o2;
  logic [127:0] burst_o2;
  logic [127:0] burst_i2;
  logic         resp_i2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] rq[$];
  logic [63:0]  wq[$];
  logic [31:0]  exp_addr;
  logic         exp_read;
  logic [255:0] last_line;

  line_burst_adaptor dut (
    .clk(clk), .reset_n(reset_n), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  line_burst_adaptor #(.LINE_W(512), .BURST_W(128), .ADDR_W(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .address_i(address_i2), .read_i(read_i2),
    .write_i(write_i2), .line_i(line_i2), .line_o(line_o2), .resp_o(resp_o2),
    .address_o(address_o2), .read_o(read_o2), .write_o(write_o2),
    .burst_o(burst_o2), .burst_i(burst_i2), .resp_i(resp_i2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", nm);
  endtask

  // Scoreboard monitor: samples mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (read_o || write_o) begin
        check("address_o", address_o, exp_addr);
        check("read_o_vs_kind", read_o, exp_read);
      end
      if (write_o && resp_i) begin
        if (wq.size() == 0) flag("burst_unexpected");
        else check("burst_o", burst_o, wq.pop_front());
      end
      if (resp_o) begin
        if (rq.size() == 0) flag("resp_unexpected");
        else begin
          check("line_o", line_o, rq.pop_front());
          check("done_quiet", {read_o, write_o}, 2'b00);
        end
      end
    end
  end

  task automatic run_read(input logic [31:0] a, input logic [31:0] a_exp,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3,
                          input logic [255:0] l_exp, input bit tog,
                          input int exp_edges);
    logic [63:0] bb [4];
    int k;
    int edges;
    bit got;
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
    k = 0; edges = 0; got = 0;
    exp_addr = a_exp;
    exp_read = 1'b1;
    rq.push_back(l_exp);
    last_line = l_exp;
    address_i = a;
    read_i = 1'b1;
    @(posedge clk); #1;
    read_i = 1'b0;
    while (!got && edges < 40) begin
      resp_i  = (k < 4) && (!tog || (edges % 2 == 0));
      burst_i = (k < 4) ? bb[k] : 64'h0;
      @(posedge clk); #1;
      edges++;
      if (resp_i) k++;
      if (resp_o) got = 1;
    end
    resp_i = 1'b0;
    check("rd_latency_edges", edges, exp_edges);
    @(posedge clk); #1;
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] a_exp,
                           input logic [255:0] l, input bit both, input bit tog,
                           input int exp_edges);
    int k;
    int edges;
    bit got;
    k = 0; edges = 0; got = 0;
    exp_addr = a_exp;
    exp_read = 1'b0;
    for (int i = 0; i < 4; i++) wq.push_back(l[i*64 +: 64]);
    rq.push_back(last_line);
    address_i = a;
    line_i = l;
    write_i = 1'b1;
    read_i = both;
    @(posedge clk); #1;
    write_i = 1'b0;
    read_i = 1'b0;
    line_i = '0;
    while (!got && edges < 40) begin
      resp_i = (k < 4) && (!tog || (edges % 2 == 0));
      @(posedge clk); #1;
      edges++;
      if (resp_i) k++;
      if (resp_o) got = 1;
    end
    resp_i = 1'b0;
    check("wr_latency_edges", edges, exp_edges);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    address_i = '0; read_i = 1'b0; write_i = 1'b0; line_i = '0;
    burst_i = '0; resp_i = 1'b0;
    address_i2 = '0; read_i2 = 1'b0; write_i2 = 1'b0; line_i2 = '0;
    burst_i2 = '0; resp_i2 = 1'b0;
    exp_addr = '0; exp_read = 1'b0; last_line = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_line_o", line_o, '0);
    check("rst_address_o", address_o, '0);
    check("rst_burst_o", burst_o, '0);
    check("rst_strobes", {read_o, write_o, resp_o}, 3'b000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Read, continuous beats
`ifdef LBA_CRITICAL_WORD_FIRST_EN
    run_read(32'h0000_1234, 32'h0000_1230, 64'hA0, 64'hA1, 64'hA2, 64'hA3,
             {64'hA1, 64'hA0, 64'hA3, 64'hA2}, 1'b0, 4);
`else
    run_read(32'h0000_1234, 32'h0000_1220, 64'hA0, 64'hA1, 64'hA2, 64'hA3,
             {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0, 4);
`endif

    // Write with stalled beats, unaligned request address
    run_write(32'h0000_5008, 32'h0000_5000,
              {64'hD3D3_0003, 64'hD2D2_0002, 64'hD1D1_0001, 64'hD0D0_0000},
              1'b0, 1'b1, 7);

    // Simultaneous read and write: write wins
    run_write(32'h0000_6040, 32'h0000_6040,
              {64'hE3, 64'hE2, 64'hE1, 64'hE0}, 1'b1, 1'b0, 4);

    // Read from beat 2 of the line
`ifdef LBA_CRITICAL_WORD_FIRST_EN
    run_read(32'h0000_1230, 32'h0000_1230, 64'hB0, 64'hB1, 64'hB2, 64'hB3,
             {64'hB1, 64'hB0, 64'hB3, 64'hB2}, 1'b0, 4);
`else
    run_read(32'h0000_1230, 32'h0000_1220, 64'hB0, 64'hB1, 64'hB2, 64'hB3,
             {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 1'b0, 4);
`endif

    // Stalled read
    run_read(32'h0000_7700, 32'h0000_7700, 64'hC0, 64'hC1, 64'hC2, 64'hC3,
             {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 1'b1, 7);

    // Reset pulsed mid-read after three beats
    exp_addr = 32'h0000_2220;
    exp_read = 1'b1;
    address_i = 32'h0000_2220;
    read_i = 1'b1;
    @(posedge clk); #1;
    read_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1;
      burst_i = 64'h99 + 64'(i);
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    check("pre_rst_read_o", read_o, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_rst_read_o", read_o, 1'b0);
    check("async_rst_line_o", line_o, '0);
    check("async_rst_address_o", address_o, '0);
    #1;
    reset_n = 1'b1;
    last_line = '0;
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (resp_o) seen++;
      end
      check("aborted_no_resp", seen, 0);
    end

    // Read after abort completes normally
    run_read(32'h0000_3300, 32'h0000_3300, 64'hF0, 64'hF1, 64'hF2, 64'hF3,
             {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1'b0, 4);

    // Wide instance: 512-bit line, 128-bit beats
    begin
      logic [127:0] cc [4];
      int k;
      int edges;
      bit got;
      cc[0] = 128'hC0; cc[1] = 128'hC1; cc[2] = 128'hC2; cc[3] = 128'hC3;
      k = 0; edges = 0; got = 0;
      address_i2 = 32'h1234_5678;
      read_i2 = 1'b1;
      @(posedge clk); #1;
      read_i2 = 1'b0;
`ifdef LBA_CRITICAL_WORD_FIRST_EN
      check("wide_address_o", address_o2, 32'h1234_5670);
`else
      check("wide_address_o", address_o2, 32'h1234_5640);
`endif
      check("wide_read_o", read_o2, 1'b1);
      while (!got && edges < 40) begin
        resp_i2 = (k < 4);
        burst_i2 = (k < 4) ? cc[k] : 128'h0;
        @(posedge clk); #1;
        edges++;
        if (resp_i2) k++;
        if (resp_o2) got = 1;
      end
      resp_i2 = 1'b0;
      check("wide_latency_edges", edges, 4);
`ifdef LBA_CRITICAL_WORD_FIRST_EN
      check("wide_line_o", line_o2, {128'hC0, 128'hC3, 128'hC2, 128'hC1});
`else
      check("wide_line_o", line_o2, {128'hC3, 128'hC2, 128'hC1, 128'hC0});
`endif
    end

    repeat (3) @(posedge clk);
    #1;
    check("resp_queue_drained", rq.size(), 0);
    check("beat_queue_drained", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
